// File: rtl/memory_pkg.sv
// memory_pkg: shared FSM state type and byte-strobe merge helper used by
// main_memory and main_memory_array.
package memory_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   // The merge helper works on a fixed maximum width; callers zero-extend
   // their words into it and truncate the result back to their own width.
   localparam int MERGE_MAX_W  = 1024;
   localparam int MERGE_MAX_SW = MERGE_MAX_W / 8;

   // Replace byte k of old_word with byte k of new_word wherever strb[k] is set.
   function automatic logic [MERGE_MAX_W-1:0] merge_strobe(
      input logic [MERGE_MAX_W-1:0]  old_word,
      input logic [MERGE_MAX_W-1:0]  new_word,
      input logic [MERGE_MAX_SW-1:0] strb
   );
      logic [MERGE_MAX_W-1:0] merged;
      merged = old_word;
      for (int k = 0; k < MERGE_MAX_SW; k++) begin
         if (strb[k]) begin
            merged[8*k +: 8] = new_word[8*k +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/main_memory_array.sv
// main_memory_array: word storage with byte-strobed write and a range-checked
// combinational read of one address. Out-of-range writes are dropped and
// out-of-range reads return zero. Storage has no reset.
module main_memory_array
   import memory_pkg::*;
#(
   parameter int MW    = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          write_en,
   input  logic [AW-1:0] write_pos,
   input  logic [MW-1:0] write_data,
   input  logic [MW/8-1:0] write_strb,
   input  logic [AW-1:0] read_pos,
   output logic [MW-1:0] read_word
);

   // One extra bit so a depth equal to 2**AW is still representable.
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [MW-1:0] mem [DEPTH];
   logic          write_in_range;
   logic          read_in_range;

   assign write_in_range = ({1'b0, write_pos} < DEPTH_W);
   assign read_in_range  = ({1'b0, read_pos} < DEPTH_W);

   // Byte-strobed write of in-range addresses; an all-zero strobe leaves the word intact.
   always_ff @(posedge clk) begin
      if (write_en && write_in_range) begin
         mem[write_pos] <= MW'(merge_strobe(MERGE_MAX_W'(mem[write_pos]),
                                            MERGE_MAX_W'(write_data),
                                            MERGE_MAX_SW'(write_strb)));
      end
   end

   // Combinational read with range check.
   always_comb begin
      read_word = '0;
      if (read_in_range) begin
         read_word = mem[read_pos];
      end
   end

endmodule

// File: rtl/main_memory.sv
// main_memory: word-addressed backing store with a fixed-latency read port
// (IDLE -> WAIT -> RESP handshake) and an always-accepted strobed write port.
// Read data is captured when the request is accepted.
// Optional build macro MAIN_MEMORY_RAW_BYPASS_EN: a same-cycle write to the
// address being accepted for read is merged into the captured word.
module main_memory
   import memory_pkg::*;
#(
   parameter  int MEMDATAWIDTH = 32,
   parameter  int MEMDEPTH     = 1024,
   parameter  int READ_LATENCY = 2,
   localparam int MW           = MEMDATAWIDTH,
   localparam int MD           = $clog2(MEMDEPTH),
   localparam int SW           = MW / 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          mem_read_en_i,
   input  logic [MD-1:0] mem_read_pos_i,
   output logic          mem_read_ready_o,
   output logic [MW-1:0] mem_read_data_o,
   output logic          mem_read_valid_o,
   input  logic          mem_write_en_i,
   input  logic [MD-1:0] mem_write_pos_i,
   input  logic [MW-1:0] mem_write_data_i,
   input  logic [SW-1:0] mem_write_strb_i
);

   // Counter only needs to hold READ_LATENCY-1.
   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   mem_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [MW-1:0] cap_reg, cap_next;
   logic [MW-1:0] read_word;
   logic [MW-1:0] accept_word;

   main_memory_array #(
      .MW    (MW),
      .DEPTH (MEMDEPTH),
      .AW    (MD)
   ) u_array (
      .clk        (clk_i),
      .write_en   (mem_write_en_i),
      .write_pos  (mem_write_pos_i),
      .write_data (mem_write_data_i),
      .write_strb (mem_write_strb_i),
      .read_pos   (mem_read_pos_i),
      .read_word  (read_word)
   );

`ifdef MAIN_MEMORY_RAW_BYPASS_EN
   localparam logic [MD:0] DEPTH_W = (MD+1)'(MEMDEPTH);
   logic bypass_hit;

   // Forward the in-flight write into the captured word (read-after-write).
   assign bypass_hit  = mem_write_en_i && (mem_write_pos_i == mem_read_pos_i) &&
                        ({1'b0, mem_read_pos_i} < DEPTH_W);
   assign accept_word = bypass_hit ?
                        MW'(merge_strobe(MERGE_MAX_W'(read_word),
                                         MERGE_MAX_W'(mem_write_data_i),
                                         MERGE_MAX_SW'(mem_write_strb_i))) :
                        read_word;
`else
   // Read-before-write: the array still holds the old word this cycle.
   assign accept_word = read_word;
`endif

   // State, latency counter and captured read word.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         cap_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         cap_reg   <= cap_next;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cap_next   = cap_reg;
      unique case (state_reg)
         IDLE: begin
            if (mem_read_en_i) begin
               cap_next   = accept_word;
               cnt_next   = CW'(READ_LATENCY - 1);
               state_next = (READ_LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
               state_next = RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mem_read_ready_o = (state_reg == IDLE);
   assign mem_read_valid_o = (state_reg == RESP);
   assign mem_read_data_o  = (state_reg == RESP) ? cap_reg : '0;

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: three main_memory instances (READ_LATENCY 1, 2, 4;
// MEMDEPTH 1000) share one stimulus stream. A transaction-level model
// (memory contents plus per-instance busy window) predicts ready/valid/data
// every cycle; directed literal checks pin returned words, latency and
// pulse counts.
module tb_main_memory;

   localparam int MW    = 32;
   localparam int DEPTH = 1000;
   localparam int MD    = $clog2(DEPTH);
   localparam int SW    = MW / 8;
   localparam int NI    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_en = 1'b0;
   logic [MD-1:0] rd_pos = '0;
   logic          wr_en = 1'b0;
   logic [MD-1:0] wr_pos = '0;
   logic [MW-1:0] wr_data = '0;
   logic [SW-1:0] wr_strb = '0;

   logic          rdy [NI];
   logic          vld [NI];
   logic [MW-1:0] dat [NI];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      main_memory #(
         .MEMDATAWIDTH (MW),
         .MEMDEPTH     (DEPTH),
         .READ_LATENCY ((gi == 0) ? 1 : ((gi == 1) ? 2 : 4))
      ) u_dut (
         .clk_i            (clk),
         .rst_ni           (rst_n),
         .mem_read_en_i    (rd_en),
         .mem_read_pos_i   (rd_pos),
         .mem_read_ready_o (rdy[gi]),
         .mem_read_data_o  (dat[gi]),
         .mem_read_valid_o (vld[gi]),
         .mem_write_en_i   (wr_en),
         .mem_write_pos_i  (wr_pos),
         .mem_write_data_i (wr_data),
         .mem_write_strb_i (wr_strb)
      );
   end

   int            lat [NI] = '{1, 2, 4};
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   bit            pend [NI];
   int            vcyc [NI];
   logic [MW-1:0] vdat [NI];
   int            vcount [NI];
   logic [MW-1:0] last_data [NI];
   int            acc_cyc [NI];
   int            last_lat [NI];
   logic [MW-1:0] mem_m [int];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [MW-1:0] apply_strb(input logic [MW-1:0] o, input logic [MW-1:0] n,
                                                input logic [SW-1:0] s);
      logic [MW-1:0] m;
      for (int k = 0; k < SW; k++) m[8*k +: 8] = {8{s[k]}};
      return (o & ~m) | (n & m);
   endfunction

   function automatic logic [MW-1:0] mread(input int p);
      if (p >= DEPTH) return '0;
      if (mem_m.exists(p)) return mem_m[p];
      return '0;
   endfunction

   // Per-cycle model and compare, sampled on the falling edge.
   initial begin
      forever begin
         logic          exp_v;
         logic [MW-1:0] rdata;
         bit            acc;
         @(negedge clk);
         cyc++;
         for (int i = 0; i < NI; i++) begin
            if (!rst_n) pend[i] = 1'b0;
            exp_v = pend[i] && (vcyc[i] == cyc);
            chk($sformatf("ready[L=%0d]", lat[i]), 32'(rdy[i]), 32'(!pend[i]));
            chk($sformatf("valid[L=%0d]", lat[i]), 32'(vld[i]), 32'(exp_v));
            chk($sformatf("data[L=%0d]", lat[i]), dat[i], exp_v ? vdat[i] : 32'h0);
            if (vld[i]) begin
               vcount[i]++;
               last_data[i] = dat[i];
               last_lat[i]  = cyc - acc_cyc[i];
            end
            if (rst_n && rd_en && rdy[i]) acc_cyc[i] = cyc;
         end
         if (rst_n) begin
            rdata = mread(int'(rd_pos));
`ifdef MAIN_MEMORY_RAW_BYPASS_EN
            if (wr_en && (wr_pos == rd_pos) && (int'(rd_pos) < DEPTH))
               rdata = apply_strb(rdata, wr_data, wr_strb);
`endif
            for (int i = 0; i < NI; i++) begin
               acc = !pend[i] && rd_en;
               if (pend[i] && (vcyc[i] == cyc)) pend[i] = 1'b0;
               if (acc) begin
                  pend[i] = 1'b1;
                  vcyc[i] = cyc + lat[i];
                  vdat[i] = rdata;
               end
            end
            if (wr_en && (int'(wr_pos) < DEPTH))
               mem_m[int'(wr_pos)] = apply_strb(mread(int'(wr_pos)), wr_data, wr_strb);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (6) tick();
   endtask

   task automatic wr(input int p, input logic [MW-1:0] d, input logic [SW-1:0] s);
      $display("write pos=%0d data=%h strb=%b", p, d, s);
      wr_en = 1'b1; wr_pos = MD'(p); wr_data = d; wr_strb = s;
      tick();
      wr_en = 1'b0; wr_strb = '0;
   endtask

   task automatic rd(input int p);
      $display("read  pos=%0d", p);
      rd_en = 1'b1; rd_pos = MD'(p);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic rw(input int p, input logic [MW-1:0] d, input logic [SW-1:0] s);
      $display("read+write pos=%0d data=%h strb=%b", p, d, s);
      rd_en = 1'b1; rd_pos = MD'(p);
      wr_en = 1'b1; wr_pos = MD'(p); wr_data = d; wr_strb = s;
      tick();
      rd_en = 1'b0; wr_en = 1'b0; wr_strb = '0;
   endtask

   task automatic chk_all(input string name, input logic [MW-1:0] exp);
      for (int i = 0; i < NI; i++) chk($sformatf("%s[L=%0d]", name, lat[i]), last_data[i], exp);
   endtask

   initial begin
      int v0 [NI];
      int exp_cnt [NI];
      exp_cnt = '{6, 4, 3};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset_ready[L=%0d]", lat[i]), 32'(rdy[i]), 32'h1);
         chk($sformatf("reset_valid[L=%0d]", lat[i]), 32'(vld[i]), 32'h0);
      end

      wr(5, 32'hDEADBEEF, 4'hF);
      wr(7, 32'h11223344, 4'hF);
      wr(9, 32'h00000000, 4'hF);
      tick();

      rd(5); drain();
      chk_all("rd5", 32'hDEADBEEF);
      for (int i = 0; i < NI; i++) chk($sformatf("latency[L=%0d]", lat[i]), 32'(last_lat[i]), 32'(lat[i]));

      wr(7, 32'hAABBCCDD, 4'b0101);
      rd(7); drain();
      chk_all("partial7", 32'h11BB33DD);

      rw(9, 32'h12345678, 4'hF); drain();
`ifdef MAIN_MEMORY_RAW_BYPASS_EN
      chk_all("same_cycle9", 32'h12345678);
`else
      chk_all("same_cycle9", 32'h00000000);
`endif

      rd(9);
      wr(9, 32'hFFFFFFFF, 4'hF);
      drain();
      chk_all("inflight9", 32'h12345678);

      rd(1010); drain();
      chk_all("oor_read", 32'h0);
      wr(1010, 32'hCAFEF00D, 4'hF);
      rd(1010); drain();
      chk_all("oor_write", 32'h0);

      wr(5, 32'h00000000, 4'h0);
      rd(5); drain();
      chk_all("zero_strb", 32'hDEADBEEF);

      for (int i = 0; i < NI; i++) v0[i] = vcount[i];
      $display("read  pos=5 held for 12 cycles");
      rd_en = 1'b1; rd_pos = MD'(5);
      repeat (12) tick();
      rd_en = 1'b0;
      drain();
      for (int i = 0; i < NI; i++)
         chk($sformatf("held_pulses[L=%0d]", lat[i]), 32'(vcount[i] - v0[i]), 32'(exp_cnt[i]));

      for (int i = 0; i < NI; i++) v0[i] = vcount[i];
      rd(5);
      $display("reset pulse during wait");
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) chk($sformatf("midreset_ready[L=%0d]", lat[i]), 32'(rdy[i]), 32'h1);
      tick();
      rst_n = 1'b1;
      drain();
      for (int i = 0; i < NI; i++)
         chk($sformatf("discarded[L=%0d]", lat[i]), 32'(vcount[i] - v0[i]), 32'h0);

      rd(5); drain();
      chk_all("after_reset5", 32'hDEADBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
- Word-addressed synchronous backing store.
- Sits directly downstream of the memory controller: it consumes the controller's single arbitrated read request stream (en/pos) and returns data with a valid pulse.
- It also accepts the direct write stream from the M stage.
- Read latency is configurable so the upstream arbitration FSM can be exercised with multi-cycle waits.

Parameters:
- MEMDATAWIDTH, 32, word width in bits; must be a multiple of 8.
- MEMDEPTH, 1024, number of words; need not be a power of two.
- READ_LATENCY, 2, cycles from request accept to valid pulse; must be >= 1.
- Derived: MW = MEMDATAWIDTH, MD = $clog2(MEMDEPTH), SW = MW/8.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_read_en_i  in  1  read request strobe.
- mem_read_pos_i  in  MD  read word address.
- mem_read_ready_o  out  1  high when a read request will be accepted this cycle.
- mem_read_data_o  out  MW  read data; valid only while mem_read_valid_o is high.
- mem_read_valid_o  out  1  one-cycle pulse marking returned data.
- mem_write_en_i  in  1  write strobe.
- mem_write_pos_i  in  MD  write word address.
- mem_write_data_i  in  MW  write data.
- mem_write_strb_i  in  SW  byte enables; bit k covers bits [8k+7:8k].

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE, mem_read_valid_o = 0, mem_read_data_o = 0, latency counter = 0, captured read data = 0.
  - mem_read_ready_o = 1 after reset.
  - Storage array is not cleared.
  - Reset asserted mid-read discards the pending read; no valid pulse is produced for it.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - ready = 1.
    - If mem_read_en_i is high: capture array[pos] (or 0 if out of range) into the read-data register, load counter = READ_LATENCY-1.
    - Go to RESP if READ_LATENCY == 1, else go to WAIT.
  - WAIT:
    - ready = 0; counter decrements each cycle.
    - Go to RESP when the counter reaches 1 at the clock edge (i.e. the next state is RESP when counter == 1).
  - RESP:
    - ready = 0, valid = 1, data = captured word.
    - Always go to IDLE next cycle. There is no back-to-back acceptance in RESP.
- Timing: a request accepted at edge t gives valid high in cycle t+READ_LATENCY, exactly one cycle wide.
- mem_read_en_i while ready = 0: ignored. The request is not queued. The upstream block must hold or re-issue the request.
- Outside RESP: mem_read_data_o = 0 and valid = 0.
- Writes:
  - Accepted every cycle regardless of FSM state.
  - array[pos] byte k is updated iff mem_write_strb_i[k] is set.
  - A write with all strobes 0 is a no-op.
- Read data is captured at accept. A write to the same address during WAIT/RESP does not alter the in-flight read data.
- Same-cycle read accept and write to the same address: read returns the OLD word (read-before-write), unless the optional feature is enabled.
- Out of range (pos >= MEMDEPTH):
  - Read returns 0 with normal latency and valid pulse.
  - Write is dropped.

Optional Feature:
- Macro: MAIN_MEMORY_RAW_BYPASS_EN.
- Defined: on same-cycle read accept and write to the same in-range address, the captured word is the merge of the old word and the new strobed bytes (i.e. the new value).
- Undefined: read-before-write as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package memory_pkg holds:
  - the mem_state_t typedef (IDLE, WAIT, RESP);
  - a helper function for the strobe merge (old word, new word, strobe -> merged word), reused by the bypass path and the array write.
- One sub-module: main_memory_array.
  - Holds the storage reg array, the byte-strobed write, and the combinational read of one address with range check.
  - The FSM, counter and output registers stay in main_memory.

Test Plan:
- Reset, then READ_LATENCY=2: write 0xDEADBEEF with strobe 4'hF to pos 5; read pos 5 at edge t -> valid high only in cycle t+2, data 0xDEADBEEF; ready low in cycles t+1 and t+2.
- READ_LATENCY=1: read pos 5 at t -> valid at t+1. Hold en high continuously -> accepts at t, t+2, t+4, ...; exactly one valid pulse per accept.
- Partial strobe: word at pos 7 = 0x11223344; write 0xAABBCCDD with strb 4'b0101 -> readback 0x11BB33DD.
- Same-cycle read and write to pos 9 (old 0x0, new 0x12345678) -> returns 0x0 without the macro, 0x12345678 with MAIN_MEMORY_RAW_BYPASS_EN. A write to pos 9 during WAIT does not change the returned data.
- MEMDEPTH=1000: read pos 1010 -> valid with data 0; write to pos 1010 then read pos 1010 -> still 0.
- Assert rst_ni low for 1 cycle in WAIT (READ_LATENCY=4) -> no valid pulse; ready = 1 immediately; previously written data is still readable afterwards.
